vote_sgpr: RTL and testbench
============================

Name: vote_sgpr

Overview:
N-channel lockstep write-back voter with an integrated shadow register file, for the fault-tolerant core cluster.
- Each redundant core's register write-back enters a per-channel skew FIFO.
- When every channel has a pending write, the FIFO heads are compared (2-channel) or majority-voted (3-channel). The agreed value is committed to the shadow register file.
- Disagreement, excessive skew or FIFO overflow moves the block to a latched FAULT state, which requests recovery.

Parameters:
- DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 5, register address width; 2**ADDR_WIDTH entries.
- NUM_CH, 2, redundant channels; legal values 2 or 3.
- SKEW_DEPTH, 4, entries per channel FIFO; power of two, ≥2.
- TIMEOUT, 15, maximum consecutive cycles with a partial set of pending writes.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we_i  in  NUM_CH  per-channel write-back valid.
- waddr_i  in  NUM_CH*ADDR_WIDTH  per-channel write address; channel k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- wdata_i  in  NUM_CH*DATA_WIDTH  per-channel write data, packed the same way.
- raddr_a_i  in  ADDR_WIDTH  read port A address.
- rdata_a_o  out  DATA_WIDTH  read port A data, combinational.
- raddr_b_i  in  ADDR_WIDTH  read port B address.
- rdata_b_o  out  DATA_WIDTH  read port B data, combinational.
- err_clr_i  in  1  leave FAULT / clear sticky status.
- commit_o  out  1  pulse: a voted write was committed this cycle.
- fault_o  out  1  block is in FAULT; recovery request to cores.
- fault_cause_o  out  2  00 none, 01 vote fail, 10 timeout, 11 overflow.
- fault_ch_o  out  NUM_CH  sticky mask of channels outvoted (NUM_CH=3 only).
- mismatch_cnt_o  out  8  saturating count of compare/vote disagreements.
- parity_err_o  out  1  read-port parity error (see optional feature).

Behaviour:
- Reset (asynchronous):
  - FIFOs emptied, all register entries zeroed, state IDLE.
  - All outputs 0.
  - Reset mid-operation discards pending writes and takes effect immediately.
- Register 0 reads as 0 always. Writes to address 0 are voted normally but not stored.
- Push: we_i[k]=1 while not in FAULT pushes {waddr, wdata} into FIFO k.
  - Push and pop of the same FIFO in one cycle is legal, including when full.
  - Push to a full FIFO with no pop: FAULT, cause 11; the entry is dropped.
- Vote: combinational on the FIFO heads, evaluated only when all FIFOs are non-empty. All heads pop on that edge.
  - NUM_CH=2:
    - Heads equal (addr and data) → commit.
    - Otherwise no commit; FAULT, cause 01.
  - NUM_CH=3:
    - All three equal → commit.
    - Exactly two equal → commit the majority value; set the minority bit in fault_ch_o; increment mismatch_cnt_o; no FAULT.
    - All differ → no commit; FAULT, cause 01.
  - Every 2-channel mismatch and every 3-way all-differ also increments mismatch_cnt_o. The counter saturates at 255 and is cleared only by reset.
- Latency:
  - Writes presented simultaneously at edge N are committed at edge N+1. commit_o is high during cycle N→N+1.
  - Read ports reflect the new value after edge N+1. There is no write-to-read bypass.
- FSM:
  - IDLE: all FIFOs empty.
  - WAIT: some but not all FIFOs non-empty. The timeout counter increments each WAIT cycle and resets on every pop or on leaving WAIT.
  - Counter reaches TIMEOUT → FAULT, cause 10.
  - FAULT: no pushes, no pops, no commits. fault_o=1. Register file still readable.
  - FAULT + err_clr_i → flush all FIFOs, go to IDLE, clear fault_cause_o and fault_ch_o.
  - err_clr_i outside FAULT clears fault_ch_o only.
- Simultaneous events:
  - Overflow takes priority over a vote fail in the same cycle.
  - A vote fail takes priority over a timeout.
  - The first cause is latched; later causes are ignored until cleared.

Optional Feature:
- Macro: VOTE_SGPR_PARITY_EN.
- Defined:
  - Each register entry stores an even-parity bit computed at commit.
  - Both read ports recompute parity. parity_err_o=1 combinationally when either port reads a nonzero address with a parity mismatch.
  - Register 0 never flags.
- Undefined: no parity storage; parity_err_o tied 0.

Test Plan:
- NUM_CH=2, both channels write addr 5 data 0xDEADBEEF in the same cycle → commit_o pulse one cycle later; rdata_a_o=0xDEADBEEF for raddr_a_i=5.
- NUM_CH=2, ch0 writes addr 3 data 0x11, ch1 writes the same 3 cycles later → commit 1 cycle after ch1; no fault; data 0x11 readable.
- NUM_CH=3, data 0xA, 0xA, 0xB to addr 7 → register 7=0xA; fault_ch_o=3'b100; mismatch_cnt_o=1; fault_o=0.
- NUM_CH=2, ch0 writes addr 4 data 1, ch1 writes addr 4 data 2 → no commit; fault_o=1; fault_cause_o=01; register 4 unchanged. Assert err_clr_i → IDLE, fault_o=0.
- NUM_CH=2, only ch0 writes, ch1 silent for 15 cycles → fault_cause_o=10. Separately, ch0 writes 5 times with ch1 silent (SKEW_DEPTH=4) → fault_cause_o=11.
- VOTE_SGPR_PARITY_EN defined, commit 0x1 to addr 9, bench forces a stored bit flip, read addr 9 → parity_err_o=1. Read addr 0 → parity_err_o=0.

Source files
------------

// File: rtl/vote_sgpr.sv
// vote_sgpr: lockstep write-back voter with an integrated shadow register file.
//
// Each redundant core's write-back is queued in its own skew FIFO. When every
// FIFO holds an entry, the heads are compared (2 channels) or majority-voted
// (3 channels). The agreed value is then written into the shadow register file.
// A disagreement that cannot be resolved, a partial set of writes held for too
// long, or a FIFO overflow puts the block into a latched FAULT state.
//
// Ports:
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   we_i             per-channel write-back valid
//   waddr_i/wdata_i  per-channel write address/data; channel k at [k*W +: W]
//   raddr_a_i/_b_i   read port addresses
//   rdata_a_o/_b_o   combinational read data (register 0 always reads 0)
//   err_clr_i        leave FAULT; outside FAULT clears fault_ch_o only
//   commit_o         a voted write commits on the coming edge
//   fault_o          block is in FAULT (recovery request)
//   fault_cause_o    00 none, 01 vote fail, 10 timeout, 11 overflow
//   fault_ch_o       sticky mask of outvoted channels (3-channel only)
//   mismatch_cnt_o   saturating count of disagreements
//   parity_err_o     read-port parity error
//
// Optional feature: define VOTE_SGPR_PARITY_EN to store an even-parity bit per
// register entry and check it on both read ports. Without it parity_err_o is 0.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | all FIFOs empty
// ST_WAIT  | some, not all, FIFOs hold entries; skew timer running
// ST_VOTE  | all FIFOs hold entries; heads voted and popped each cycle
// ST_FAULT | latched fault; no push, pop or commit until err_clr_i

module vote_sgpr #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_CH     = 2,
   parameter int SKEW_DEPTH = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_CH-1:0]              we_i,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]   waddr_i,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   wdata_i,
   input  logic [ADDR_WIDTH-1:0]          raddr_a_i,
   output logic [DATA_WIDTH-1:0]          rdata_a_o,
   input  logic [ADDR_WIDTH-1:0]          raddr_b_i,
   output logic [DATA_WIDTH-1:0]          rdata_b_o,
   input  logic                           err_clr_i,
   output logic                           commit_o,
   output logic                           fault_o,
   output logic [1:0]                     fault_cause_o,
   output logic [NUM_CH-1:0]              fault_ch_o,
   output logic [7:0]                     mismatch_cnt_o,
   output logic                           parity_err_o
);

   localparam int PW   = $clog2(SKEW_DEPTH);
   localparam int CW   = PW + 1;
   localparam int EW   = ADDR_WIDTH + DATA_WIDTH;
   localparam int NREG = 1 << ADDR_WIDTH;
   localparam int TW   = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_VOTE, ST_FAULT} state_t;

   state_t                  state_q, state_d;
   logic [1:0]              cause_q, cause_d;
   logic [NUM_CH-1:0]       fault_ch_q, fault_ch_d;
   logic [7:0]              mm_cnt_q, mm_cnt_d;
   logic [TW-1:0]           tmr_q, tmr_d;
   logic [EW-1:0]           fifo_mem_q [NUM_CH][SKEW_DEPTH];
   logic [EW-1:0]           fifo_mem_d [NUM_CH][SKEW_DEPTH];
   logic [CW-1:0]           wr_ptr_q [NUM_CH];
   logic [CW-1:0]           wr_ptr_d [NUM_CH];
   logic [CW-1:0]           rd_ptr_q [NUM_CH];
   logic [CW-1:0]           rd_ptr_d [NUM_CH];
   logic [DATA_WIDTH-1:0]   regs_q [NREG];
   logic [DATA_WIDTH-1:0]   regs_d [NREG];

   logic [NUM_CH-1:0]       not_empty, full, push, ne_next;
   logic [EW-1:0]           head [NUM_CH];
   logic                    in_fault, vote_valid, vote_ok, vote_mm, vote_fail_v;
   logic                    pop, ovf, tmo;
   logic [EW-1:0]           win_entry;
   logic [NUM_CH-1:0]       minority;
   logic [ADDR_WIDTH-1:0]   win_addr;
   logic [DATA_WIDTH-1:0]   win_data;

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         not_empty[k] = wr_ptr_q[k] != rd_ptr_q[k];
         full[k]      = (wr_ptr_q[k][PW-1:0] == rd_ptr_q[k][PW-1:0]) &&
                        (wr_ptr_q[k][PW] != rd_ptr_q[k][PW]);
         head[k]      = fifo_mem_q[k][rd_ptr_q[k][PW-1:0]];
      end
   end

   if (NUM_CH == 3) begin : g_vote3
      logic eq01, eq02, eq12;
      always_comb begin
         eq01      = head[0] == head[1];
         eq02      = head[0] == head[2];
         eq12      = head[1] == head[2];
         vote_ok   = 1'b1;
         vote_mm   = 1'b0;
         win_entry = head[0];
         minority  = '0;
         if (eq01 && eq12) begin
            vote_mm = 1'b0;
         end else if (eq01) begin
            vote_mm     = 1'b1;
            minority[2] = 1'b1;
         end else if (eq02) begin
            vote_mm     = 1'b1;
            minority[1] = 1'b1;
         end else if (eq12) begin
            vote_mm     = 1'b1;
            minority[0] = 1'b1;
            win_entry   = head[1];
         end else begin
            vote_ok = 1'b0;
            vote_mm = 1'b1;
         end
      end
   end else begin : g_vote2
      always_comb begin
         vote_ok   = head[0] == head[1];
         vote_mm   = !vote_ok;
         win_entry = head[0];
         minority  = '0;
      end
   end

   assign in_fault    = state_q == ST_FAULT;
   assign vote_valid  = (&not_empty) && !in_fault;
   assign vote_fail_v = vote_valid && !vote_ok;
   // A failed vote leaves the heads in place, so a push into a full FIFO in
   // the same cycle is still an overflow (and wins the cause priority).
   assign pop         = vote_valid && vote_ok;
   assign push        = we_i & {NUM_CH{!in_fault}};
   assign ovf         = (|(push & full)) && !pop;
   assign win_addr    = win_entry[EW-1 -: ADDR_WIDTH];
   assign win_data    = win_entry[DATA_WIDTH-1:0];

   always_comb begin
      fifo_mem_d = fifo_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      ne_next    = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (push[k] && (!full[k] || pop)) begin
            fifo_mem_d[k][wr_ptr_q[k][PW-1:0]] =
               {waddr_i[k*ADDR_WIDTH +: ADDR_WIDTH], wdata_i[k*DATA_WIDTH +: DATA_WIDTH]};
            wr_ptr_d[k] = wr_ptr_q[k] + CW'(1);
         end
         if (pop) begin
            rd_ptr_d[k] = rd_ptr_q[k] + CW'(1);
         end
         ne_next[k] = wr_ptr_d[k] != rd_ptr_d[k];
      end

      // A push that completes the set on the last allowed cycle is not a timeout.
      tmo = (state_q == ST_WAIT) && (tmr_q == TW'(1)) && !(&ne_next);

      state_d    = state_q;
      cause_d    = cause_q;
      fault_ch_d = fault_ch_q;
      mm_cnt_d   = mm_cnt_q;
      tmr_d      = TW'(TIMEOUT);
      regs_d     = regs_q;

      if (in_fault) begin
         if (err_clr_i) begin
            state_d    = ST_IDLE;
            cause_d    = 2'b00;
            fault_ch_d = '0;
            for (int k = 0; k < NUM_CH; k++) begin
               wr_ptr_d[k] = '0;
               rd_ptr_d[k] = '0;
            end
         end
      end else begin
         if (err_clr_i) begin
            fault_ch_d = '0;
         end
         if (vote_valid) begin
            if (vote_mm && (mm_cnt_q != 8'hFF)) begin
               mm_cnt_d = mm_cnt_q + 8'd1;
            end
            fault_ch_d = fault_ch_d | minority;
         end
         if (pop && (win_addr != '0)) begin
            regs_d[win_addr] = win_data;
         end

         if (ovf) begin
            state_d = ST_FAULT;
            cause_d = 2'b11;
         end else if (vote_fail_v) begin
            state_d = ST_FAULT;
            cause_d = 2'b01;
         end else if (tmo) begin
            state_d = ST_FAULT;
            cause_d = 2'b10;
         end else if (&ne_next) begin
            state_d = ST_VOTE;
         end else if (|ne_next) begin
            state_d = ST_WAIT;
         end else begin
            state_d = ST_IDLE;
         end

         if ((state_q == ST_WAIT) && (state_d == ST_WAIT)) begin
            tmr_d = tmr_q - TW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cause_q    <= 2'b00;
         fault_ch_q <= '0;
         mm_cnt_q   <= 8'd0;
         tmr_q      <= TW'(TIMEOUT);
         for (int k = 0; k < NUM_CH; k++) begin
            wr_ptr_q[k] <= '0;
            rd_ptr_q[k] <= '0;
            for (int j = 0; j < SKEW_DEPTH; j++) begin
               fifo_mem_q[k][j] <= '0;
            end
         end
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         cause_q    <= cause_d;
         fault_ch_q <= fault_ch_d;
         mm_cnt_q   <= mm_cnt_d;
         tmr_q      <= tmr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_mem_q <= fifo_mem_d;
         regs_q     <= regs_d;
      end
   end

   assign commit_o       = pop;
   assign fault_o        = in_fault;
   assign fault_cause_o  = cause_q;
   assign fault_ch_o     = fault_ch_q;
   assign mismatch_cnt_o = mm_cnt_q;
   assign rdata_a_o      = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
   assign rdata_b_o      = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

`ifdef VOTE_SGPR_PARITY_EN
   logic par_q [NREG];
   logic par_d [NREG];

   always_comb begin
      par_d = par_q;
      if (pop && (win_addr != '0)) begin
         par_d[win_addr] = ^win_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            par_q[i] <= 1'b0;
         end
      end else begin
         par_q <= par_d;
      end
   end

   assign parity_err_o = ((raddr_a_i != '0) && ((^regs_q[raddr_a_i]) != par_q[raddr_a_i])) ||
                         ((raddr_b_i != '0) && ((^regs_q[raddr_b_i]) != par_q[raddr_b_i]));
`else
   assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_vote_sgpr.sv
// Directed bench for vote_sgpr: a 2-channel instance (dut2) and a 3-channel
// instance (dut3) driven from one linear stimulus sequence.

module tb_vote_sgpr;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  we2 = '0;
   logic [9:0]  waddr2 = '0;
   logic [63:0] wdata2 = '0;
   logic [4:0]  ra2 = '0, rb2 = '0;
   logic [31:0] rda2, rdb2;
   logic        clr2 = 1'b0;
   logic        commit2, fault2, perr2;
   logic [1:0]  cause2, fch2;
   logic [7:0]  mcnt2;

   logic [2:0]  we3 = '0;
   logic [14:0] waddr3 = '0;
   logic [95:0] wdata3 = '0;
   logic [4:0]  ra3 = '0, rb3 = '0;
   logic [31:0] rda3, rdb3;
   logic        clr3 = 1'b0;
   logic        commit3, fault3, perr3;
   logic [1:0]  cause3;
   logic [2:0]  fch3;
   logic [7:0]  mcnt3;

   int vectors = 0;
   int miscompares = 0;

   vote_sgpr #(.NUM_CH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .we_i(we2), .waddr_i(waddr2), .wdata_i(wdata2),
      .raddr_a_i(ra2), .rdata_a_o(rda2), .raddr_b_i(rb2), .rdata_b_o(rdb2),
      .err_clr_i(clr2), .commit_o(commit2), .fault_o(fault2), .fault_cause_o(cause2),
      .fault_ch_o(fch2), .mismatch_cnt_o(mcnt2), .parity_err_o(perr2)
   );

   vote_sgpr #(.NUM_CH(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .we_i(we3), .waddr_i(waddr3), .wdata_i(wdata3),
      .raddr_a_i(ra3), .rdata_a_o(rda3), .raddr_b_i(rb3), .rdata_b_o(rdb3),
      .err_clr_i(clr3), .commit_o(commit3), .fault_o(fault3), .fault_cause_o(cause3),
      .fault_ch_o(fch3), .mismatch_cnt_o(mcnt3), .parity_err_o(perr3)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive2(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
      we2    = we;
      waddr2 = {a1, a0};
      wdata2 = {d1, d0};
   endtask

   task automatic drive3(input logic [4:0] a, input logic [31:0] d0,
                         input logic [31:0] d1, input logic [31:0] d2);
      we3    = 3'b111;
      waddr3 = {a, a, a};
      wdata3 = {d2, d1, d0};
   endtask

   initial begin
      // reset state
      #12;
      chk("rst_commit2", commit2, 0);
      chk("rst_fault2", fault2, 0);
      chk("rst_cause2", cause2, 0);
      chk("rst_mcnt3", mcnt3, 0);
      rst_n = 1'b1;
      tick();

      // both channels write addr 5 together
      drive2(2'b11, 5'd5, 32'hDEADBEEF, 5'd5, 32'hDEADBEEF);
      ra2 = 5'd5;
      tick();
      we2 = '0;
      chk("t1_commit", commit2, 1);
      chk("t1_no_bypass", rda2, 0);
      tick();
      chk("t1_commit_pulse", commit2, 0);
      chk("t1_rdata", rda2, 32'hDEADBEEF);

      // ch1 lags ch0 by three cycles
      drive2(2'b01, 5'd3, 32'h11, 5'd0, 32'h0);
      tick();
      we2 = '0;
      chk("t2_early", commit2, 0);
      tick();
      tick();
      drive2(2'b10, 5'd0, 32'h0, 5'd3, 32'h11);
      tick();
      we2 = '0;
      chk("t2_commit", commit2, 1);
      chk("t2_nofault", fault2, 0);
      ra2 = 5'd3;
      tick();
      chk("t2_rdata", rda2, 32'h11);

      // compare failure
      drive2(2'b11, 5'd4, 32'h1, 5'd4, 32'h2);
      tick();
      we2 = '0;
      chk("t4_nocommit", commit2, 0);
      tick();
      ra2 = 5'd4;
      #1;
      chk("t4_fault", fault2, 1);
      chk("t4_cause", cause2, 2'b01);
      chk("t4_mcnt", mcnt2, 1);
      chk("t4_reg4", rda2, 0);
      clr2 = 1'b1;
      tick();
      clr2 = 1'b0;
      chk("t4_clr_fault", fault2, 0);
      chk("t4_clr_cause", cause2, 0);
      drive2(2'b11, 5'd6, 32'h66, 5'd6, 32'h66);
      tick();
      we2 = '0;
      chk("t4_flushed_commit", commit2, 1);
      tick();

      // skew timeout
      drive2(2'b01, 5'd2, 32'h7, 5'd0, 32'h0);
      tick();
      we2 = '0;
      for (int i = 0; i < 14; i++) tick();
      chk("t5_before_tmo", fault2, 0);
      tick();
      chk("t5_tmo_fault", fault2, 1);
      chk("t5_tmo_cause", cause2, 2'b10);
      clr2 = 1'b1;
      tick();
      clr2 = 1'b0;

      // overflow: five pushes on ch0 alone
      for (int i = 0; i < 4; i++) begin
         drive2(2'b01, 5'd2, 32'h7, 5'd0, 32'h0);
         tick();
      end
      chk("t5_full_nofault", fault2, 0);
      tick();
      we2 = '0;
      chk("t5_ovf_fault", fault2, 1);
      chk("t5_ovf_cause", cause2, 2'b11);
      clr2 = 1'b1;
      tick();
      clr2 = 1'b0;

      // overflow and vote fail in the same cycle
      for (int i = 0; i < 3; i++) begin
         drive2(2'b01, 5'd1, 32'h1, 5'd0, 32'h0);
         tick();
      end
      drive2(2'b11, 5'd1, 32'h1, 5'd1, 32'h9);
      tick();
      chk("t8_nocommit", commit2, 0);
      drive2(2'b01, 5'd1, 32'h1, 5'd0, 32'h0);
      tick();
      we2 = '0;
      chk("t8_cause_ovf", cause2, 2'b11);
      chk("t8_mcnt", mcnt2, 2);
      clr2 = 1'b1;
      tick();
      clr2 = 1'b0;

      // address 0 is voted but not stored
      drive2(2'b11, 5'd0, 32'h55, 5'd0, 32'h55);
      tick();
      we2 = '0;
      chk("t7_commit0", commit2, 1);
      tick();
      ra2 = 5'd0;
      #1;
      chk("t7_reg0", rda2, 0);

      // parity
      drive2(2'b11, 5'd9, 32'h1, 5'd9, 32'h1);
      tick();
      we2 = '0;
      tick();
      ra2 = 5'd9;
      rb2 = 5'd0;
      #1;
      chk("t6_rdata9", rda2, 32'h1);
      chk("t6_perr_clean", perr2, 0);
`ifdef VOTE_SGPR_PARITY_EN
      dut2.regs_q[9] = 32'h3;
      #1;
      chk("t6_perr_flip", perr2, 1);
      ra2 = 5'd0;
      #1;
      chk("t6_perr_reg0", perr2, 0);
      dut2.regs_q[9] = 32'h1;
`endif

      // 3-channel majority with ch2 outvoted
      drive3(5'd7, 32'hA, 32'hA, 32'hB);
      tick();
      we3 = '0;
      chk("t3_commit", commit3, 1);
      tick();
      ra3 = 5'd7;
      #1;
      chk("t3_rdata", rda3, 32'hA);
      chk("t3_fault_ch", fch3, 3'b100);
      chk("t3_mcnt", mcnt3, 1);
      chk("t3_nofault", fault3, 0);
      clr3 = 1'b1;
      tick();
      clr3 = 1'b0;
      chk("t3_clr_fault_ch", fch3, 0);

      // ch0 outvoted
      drive3(5'd8, 32'h1, 32'h2, 32'h2);
      tick();
      we3 = '0;
      tick();
      ra3 = 5'd8;
      #1;
      chk("t3b_rdata", rda3, 32'h2);
      chk("t3b_fault_ch", fch3, 3'b001);
      chk("t3b_mcnt", mcnt3, 2);

      // all three differ
      drive3(5'd10, 32'h1, 32'h2, 32'h3);
      tick();
      we3 = '0;
      chk("t3c_nocommit", commit3, 0);
      tick();
      ra3 = 5'd10;
      #1;
      chk("t3c_fault", fault3, 1);
      chk("t3c_cause", cause3, 2'b01);
      chk("t3c_mcnt", mcnt3, 3);
      chk("t3c_reg10", rda3, 0);

      // reset mid-operation
      drive2(2'b01, 5'd11, 32'hEE, 5'd0, 32'h0);
      tick();
      we2 = '0;
      ra2 = 5'd5;
      rst_n = 1'b0;
      #2;
      chk("rst_mid_fault3", fault3, 0);
      chk("rst_mid_mcnt3", mcnt3, 0);
      chk("rst_mid_reg5", rda2, 0);
      rst_n = 1'b1;
      drive2(2'b11, 5'd11, 32'hB, 5'd11, 32'hB);
      tick();
      we2 = '0;
      chk("rst_mid_commit", commit2, 1);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
